// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver driven by a 16x oversampling tick.
// The rx line is brought into the clk domain through a two-flop synchroniser.
// A four-state FSM then samples the middle of the start bit, of each data bit
// and of the stop bit. Each received byte is presented on dout together with
// frame_err and a single-cycle rx_done_tick strobe.
module uart_rx #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   output logic            rx_done_tick,
   output logic [DBIT-1:0] dout,
   output logic            frame_err
);

   // Bit-counter width: just wide enough to count up to DBIT-1.
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
   localparam logic [NW-1:0] N_ONE  = NW'(1);
   localparam logic [3:0]    S_MID  = 4'd7;
   localparam logic [3:0]    S_END  = 4'd15;
   localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } state_t;

   // Synchroniser flops: both idle high so reset never looks like a start edge.
   logic            rx_meta_q, rx_meta_d;
   logic            rx_s_q,    rx_s_d;

   // Frame state.
   state_t          state_q,   state_d;
   logic [3:0]      s_q,       s_d;
   logic [NW-1:0]   n_q,       n_d;
   logic [DBIT-1:0] b_q,       b_d;

   // Registered outputs.
   logic [DBIT-1:0] dout_q,      dout_d;
   logic            frame_err_q, frame_err_d;
   logic            rx_done_q,   rx_done_d;

   // Synchroniser next-state: rx shifts through two stages.
   always_comb begin
      rx_meta_d = rx;
      rx_s_d    = rx_meta_q;
   end

   // Synchroniser registers, reset to the idle (high) line level.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_meta_d;
         rx_s_q    <= rx_s_d;
      end
   end

   // Receiver next-state logic. The counters advance only on s_tick and are
   // otherwise changed only by the zeroing that happens on state transitions.
   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      n_d         = n_q;
      b_d         = b_q;
      dout_d      = dout_q;
      frame_err_d = frame_err_q;
      rx_done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            // A low synchronised line is a candidate start bit.
            // s_tick is not needed to leave IDLE.
            if (rx_s_q == 1'b0) begin
               state_d = START;
               s_d     = 4'd0;
            end else begin
               state_d = IDLE;
            end
         end

         START: begin
            if (s_tick) begin
               if (s_q == S_MID) begin
                  // Middle of the start bit: a line that is high again was a
                  // glitch, so drop back to IDLE without a strobe.
                  if (rx_s_q == 1'b0) begin
                     state_d = DATA;
                     s_d     = 4'd0;
                     n_d     = '0;
                  end else begin
                     state_d = IDLE;
                     s_d     = 4'd0;
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end else begin
               s_d = s_q;
            end
         end

         DATA: begin
            if (s_tick) begin
               if (s_q == S_END) begin
                  // Middle of a data bit: shift it in (the line is sent LSB first).
                  s_d = 4'd0;
                  b_d = {rx_s_q, b_q[DBIT-1:1]};
                  if (n_q == N_LAST) begin
                     state_d = STOP;
                  end else begin
                     n_d = n_q + N_ONE;
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end else begin
               s_d = s_q;
            end
         end

         STOP: begin
            if (s_tick) begin
               if (s_q == S_STOP) begin
                  // Deliver the byte even when the stop bit is low; frame_err
                  // reports that case.
                  dout_d      = b_q;
                  frame_err_d = ~rx_s_q;
                  rx_done_d   = 1'b1;
                  state_d     = IDLE;
                  s_d         = 4'd0;
               end else begin
                  s_d = s_q + 4'd1;
               end
            end else begin
               s_d = s_q;
            end
         end

         default: begin
            state_d = IDLE;
            s_d     = 4'd0;
            n_d     = '0;
         end
      endcase
   end

   // Receiver state and output registers. A synchronous reset discards any
   // partial frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         s_q         <= 4'd0;
         n_q         <= '0;
         b_q         <= '0;
         dout_q      <= '0;
         frame_err_q <= 1'b0;
         rx_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         n_q         <= n_d;
         b_q         <= b_d;
         dout_q      <= dout_d;
         frame_err_q <= frame_err_d;
         rx_done_q   <= rx_done_d;
      end
   end

   assign rx_done_tick = rx_done_q;
   assign dout         = dout_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx.
// A driver serialises frames on rx, aligned to the bench's own s_tick
// generator, and pushes the expected byte, framing flag and tick timestamp.
// A separate monitor pops one entry per rx_done_tick and compares.
module tb_uart_rx;

   localparam int DBIT    = 8;
   localparam int SB_TICK = 16;
   // Ticks from START entry to the edge that consumes the last stop tick.
   localparam int LAT     = 8 + 16 * DBIT + SB_TICK;

   logic            clk = 1'b0;
   logic            reset;
   logic            rx;
   logic            s_tick;
   logic            rx_done_tick;
   logic [DBIT-1:0] dout;
   logic            frame_err;

   uart_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx),
      .s_tick       (s_tick),
      .rx_done_tick (rx_done_tick),
      .dout         (dout),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       ferr;
      int         base;
   } exp_t;

   exp_t       exp_q[$];
   int         errors     = 0;
   int         checks     = 0;
   int         tick_total = 0;
   int         tick_div   = 4;
   int         tick_cnt   = 0;
   bit         mon_en     = 1'b0;
   logic [7:0] held_d     = 8'h00;
   logic       held_f     = 1'b0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // s_tick generator: one-cycle pulse every tick_div clocks, changed 1 time unit after posedge.
   initial begin
      s_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tick_cnt == tick_div - 1) begin
            s_tick   = 1'b1;
            tick_cnt = 0;
         end else begin
            s_tick = 1'b0;
            tick_cnt++;
         end
      end
   end

   // Running count of ticks seen by the DUT at each posedge.
   initial begin
      forever begin
         @(posedge clk);
         if (s_tick === 1'b1) tick_total++;
      end
   end

   // Monitor: one scoreboard entry per strobe; outputs must hold in between.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (reset === 1'b1) begin
               held_d = 8'h00;
               held_f = 1'b0;
            end else if (rx_done_tick !== 1'b0) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_strobe: rx_done_tick=%b dout=0x%0h frame_err=%b, no frame pending",
                           rx_done_tick, dout, frame_err);
               end else begin
                  e = exp_q.pop_front();
                  check("dout", {24'd0, dout}, {24'd0, e.data});
                  check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
                  check("strobe_latency_ticks", tick_total - e.base, LAT);
                  held_d = e.data;
                  held_f = e.ferr;
               end
            end else begin
               check("output_hold", {23'd0, frame_err, dout}, {23'd0, held_f, held_d});
            end
         end
      end
   end

   // Watchdog so the bench can never hang.
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, %0d frames pending", exp_q.size());
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   // Returns at the posedge where the DUT samples s_tick=1.
   task automatic wait_tick();
      do @(posedge clk); while (s_tick !== 1'b1);
   endtask

   // Idle line for n ticks; ends at a tick edge.
   task automatic idle(input int n);
      #2 rx = 1'b1;
      repeat (n) wait_tick();
   endtask

   // Send one frame, starting right after the current tick edge. With
   // abort=1, reset is pulsed in the middle of data bit 4 and the rest of the
   // frame is abandoned.
   task automatic send_frame(input logic [7:0] data, input logic stop, input bit abort);
      exp_t e;
      #2 rx = 1'b0;
      if (!abort) begin
         e.data = data;
         e.ferr = ~stop;
         e.base = tick_total;
         exp_q.push_back(e);
      end
      repeat (16) wait_tick();
      for (int k = 0; k < 8; k++) begin
         #2 rx = data[k];
         if (abort && k == 4) begin
            repeat (8) wait_tick();
            #2 reset = 1'b1;
            rx = 1'b1;
            @(posedge clk);
            #2 reset = 1'b0;
            #3;
            check("midreset_done", {31'd0, rx_done_tick}, 32'd0);
            check("midreset_dout", {24'd0, dout}, 32'd0);
            check("midreset_ferr", {31'd0, frame_err}, 32'd0);
            repeat (32) wait_tick();
            return;
         end
         repeat (16) wait_tick();
      end
      #2 rx = stop;
      if (stop) begin
         repeat (16) wait_tick();
      end else begin
         // Release a low stop bit just after its sample point, then idle.
         repeat (9) wait_tick();
         #2 rx = 1'b1;
         repeat (23) wait_tick();
      end
   endtask

   initial begin
      logic [7:0] rdata;
      logic       rstop;
      int         gap;
      int         w;

      reset    = 1'b1;
      rx       = 1'b0;
      tick_div = $urandom_range(4, 6);

      // Reset held for 3 cycles with the line low.
      repeat (3) @(posedge clk);
      #3;
      check("reset_done", {31'd0, rx_done_tick}, 32'd0);
      check("reset_dout", {24'd0, dout}, 32'd0);
      check("reset_ferr", {31'd0, frame_err}, 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;
      rx     = 1'b1;
      mon_en = 1'b1;
      wait_tick();
      idle(32);

      // Single byte.
      send_frame(8'hA5, 1'b1, 1'b0);
      idle(4);

      // Glitch of 3 ticks, then a clean frame.
      #2 rx = 1'b0;
      repeat (3) wait_tick();
      idle(20);
      send_frame(8'h3C, 1'b1, 1'b0);
      idle(4);

      // Framing error, followed by a clean frame.
      send_frame(8'hFF, 1'b0, 1'b0);
      send_frame(8'h00, 1'b1, 1'b0);
      idle(4);

      // Back-to-back frames.
      send_frame(8'h01, 1'b1, 1'b0);
      send_frame(8'h80, 1'b1, 1'b0);
      send_frame(8'h55, 1'b1, 1'b0);
      idle(4);

      // Mid-frame reset, then the same byte intact.
      send_frame(8'h5A, 1'b1, 1'b1);
      send_frame(8'h5A, 1'b1, 1'b0);
      idle(4);

      // Random frames with random stop bits and gaps.
      for (int i = 0; i < 20; i++) begin
         rdata = 8'($urandom);
         rstop = ($urandom_range(0, 4) != 0);
         gap   = $urandom_range(0, 3);
         if (gap != 0) idle(gap);
         send_frame(rdata, rstop, 1'b0);
      end
      idle(16);

      w = 0;
      while (exp_q.size() != 0 && w < 5000) begin
         @(posedge clk);
         w++;
      end
      check("all_frames_received", exp_q.size(), 32'd0);
      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
